// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : Tetris score/level/line bookkeeping. The level multiplier is
//               applied by repeated saturating addition.
// Revision    : 1.0 - initial release
// ============================================================================
module score_keeper #(
  parameter int MAX_SCORE       = 9999,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        newGame,
  input  logic        lineEvt,
  input  logic [2:0]  lineCount,
  input  logic        dropEvt,
  output logic [14:0] score,
  output logic [3:0]  level,
  output logic [9:0]  lines,
  output logic        busy
);

  localparam logic [15:0] c_max_score       = 16'(MAX_SCORE);
  localparam logic [10:0] c_max_lines       = 11'd999;
  localparam logic [7:0]  c_lines_per_level = 8'(LINES_PER_LEVEL);
  localparam logic [3:0]  c_max_level       = 4'(MAX_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t      r_state;
  logic [10:0] r_base;
  logic [2:0]  r_count;
  logic [3:0]  r_iter;
  logic [7:0]  r_line_in_level;
  logic        r_drop_pending;

  logic        w_line_ok;
  logic [10:0] w_base;
  logic [15:0] w_sum_drop;
  logic [15:0] w_sum_base;
  logic [14:0] w_score_drop;
  logic [14:0] w_score_acc;
  logic [10:0] w_lines_sum;
  logic [9:0]  w_lines_next;
  logic [7:0]  w_lil_sum;
  logic [3:0]  w_level_inc;

  assign w_line_ok = lineEvt && (lineCount != 3'd0) && (lineCount <= 3'd4);

  always_comb begin
    w_base = 11'd0;
    case (lineCount)
      3'd1:    w_base = 11'd40;
      3'd2:    w_base = 11'd100;
      3'd3:    w_base = 11'd300;
      3'd4:    w_base = 11'd1200;
      default: w_base = 11'd0;
    endcase
  end

  // One bit of headroom on each sum so saturation can be detected before wrap
  assign w_sum_drop   = {1'b0, score} + 16'd1;
  assign w_sum_base   = {1'b0, score} + {5'd0, r_base};
  assign w_score_drop = (w_sum_drop > c_max_score) ? c_max_score[14:0] : w_sum_drop[14:0];
  assign w_score_acc  = (w_sum_base > c_max_score) ? c_max_score[14:0] : w_sum_base[14:0];

  assign w_lines_sum  = {1'b0, lines} + {8'd0, r_count};
  assign w_lines_next = (w_lines_sum > c_max_lines) ? c_max_lines[9:0] : w_lines_sum[9:0];
  assign w_lil_sum    = r_line_in_level + {5'd0, r_count};
  assign w_level_inc  = (level >= c_max_level) ? level : level + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_base          <= 11'd0;
      r_count         <= 3'd0;
      r_iter          <= 4'd0;
      r_line_in_level <= 8'd0;
      r_drop_pending  <= 1'b0;
      score           <= 15'd0;
      level           <= 4'd0;
      lines           <= 10'd0;
      busy            <= 1'b0;
    end else if (newGame) begin
      r_state         <= S_IDLE;
      r_line_in_level <= 8'd0;
      r_drop_pending  <= 1'b0;
      score           <= 15'd0;
      level           <= 4'd0;
      lines           <= 10'd0;
      busy            <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A queued drop is served first; a fresh drop that cannot be served
          // this cycle takes the single pending slot.
          if (r_drop_pending || (dropEvt && !w_line_ok)) begin
            score <= w_score_drop;
          end
          r_drop_pending <= dropEvt && (w_line_ok || r_drop_pending);
          if (w_line_ok) begin
            r_base  <= w_base;
            r_count <= lineCount;
            r_iter  <= level + 4'd1;
            r_state <= S_ACCUM;
            busy    <= 1'b1;
          end
        end

        S_ACCUM: begin
          score  <= w_score_acc;
          r_iter <= r_iter - 4'd1;
          if (r_iter == 4'd1) begin
            r_state <= S_UPDATE;
          end
          if (dropEvt) begin
            r_drop_pending <= 1'b1;
          end
        end

        S_UPDATE: begin
          lines <= w_lines_next;
          if (w_lil_sum >= c_lines_per_level) begin
            r_line_in_level <= w_lil_sum - c_lines_per_level;
            level           <= w_level_inc;
          end else begin
            r_line_in_level <= w_lil_sum;
          end
          if (dropEvt) begin
            r_drop_pending <= 1'b1;
          end
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
